// File: rtl/offchip_link_rx.sv
// Off-chip link receiver: buffers 32-bit link words in a small FIFO and
// reassembles byte-lane-interleaved 64-bit payloads behind a valid/ready port.
// One token pulse is returned per TOKEN_WORDS words drained from the FIFO.
//
// Handshake: data_out is transferred on a rising edge where valid_out & ready.
// While valid_out is high and ready is low, data_out holds its value. The link
// side has no backpressure; a word that arrives while the FIFO is full is
// dropped and flagged on the sticky overflow output.
module offchip_link_rx #(
  parameter int DEPTH       = 8,
  parameter int TOKEN_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              link_data,
  input  logic                     link_valid,
  output logic [63:0]              data_out,
  output logic                     valid_out,
  input  logic                     ready,
  output logic                     token_out,
  output logic                     overflow,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TOKEN_WORDS > 1) ? $clog2(TOKEN_WORDS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TOK_LAST = TW'(TOKEN_WORDS - 1);

  typedef enum logic [1:0] {
    ST_LO  = 2'd0,
    ST_HI  = 2'd1,
    ST_OUT = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [TW-1:0] pop_cnt;
  logic [31:0]   lo_word;
  logic [31:0]   rd_word;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Full/empty come from start-of-cycle occupancy, so a same-cycle pop never
  // makes room for a push.
  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    push    = link_valid & ~full;
    rd_word = mem[rptr];
    pop     = 1'b0;
    case (state)
      ST_LO:   pop = ~empty;
      ST_HI:   pop = ~empty;
      ST_OUT:  pop = ~empty & ready;
      default: pop = 1'b0;
    endcase
  end

  assign dbg_state = state;
  assign dbg_count = count;

  // Receive storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= link_data;
  end

  // Pointers, occupancy, token cadence and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pop_cnt   <= '0;
      token_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) pop_cnt <= (pop_cnt == TOK_LAST) ? '0 : pop_cnt + 1'b1;
      token_out <= pop & (pop_cnt == TOK_LAST);
      if (link_valid & full) overflow <= 1'b1;
    end
  end

  // Assembler: LO collects the low word, HI completes the payload, OUT
  // presents it and may start the next frame on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LO;
      lo_word   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      case (state)
        ST_LO: begin
          if (!empty) begin
            lo_word <= rd_word;
            state   <= ST_HI;
          end
        end
        ST_HI: begin
          if (!empty) begin
            data_out  <= {rd_word[31:16], lo_word[31:16],
                          rd_word[15:0],  lo_word[15:0]};
            valid_out <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (ready) begin
            valid_out <= 1'b0;
            if (!empty) begin
              lo_word <= rd_word;
              state   <= ST_HI;
            end else begin
              state <= ST_LO;
            end
          end
        end
        default: begin
          state     <= ST_LO;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_offchip_link_rx.sv
// Bench for offchip_link_rx: scoreboard of expected payloads, token monitor,
// directed frame/backpressure/overflow/reset cases and a credit-honouring
// random-ready stream.
module tb_offchip_link_rx;

  localparam int DEPTH = 8;
  localparam int TOKEN_WORDS = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] link_data;
  logic        link_valid;
  logic [63:0] data_out;
  logic        valid_out;
  logic        ready;
  logic        token_out;
  logic        overflow;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_count;

  int n_checks = 0;
  int n_fail = 0;
  int n_payloads = 0;
  int cyc = 0;
  int c0;
  int credits;
  logic [63:0] exp_q[$];
  int tok_cyc[$];
  logic [31:0] lo_hold;
  bit have_lo;

  offchip_link_rx #(.DEPTH(DEPTH), .TOKEN_WORDS(TOKEN_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .link_data(link_data), .link_valid(link_valid),
    .data_out(data_out), .valid_out(valid_out), .ready(ready),
    .token_out(token_out), .overflow(overflow),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [31:0] lo, input logic [31:0] hi);
    return {hi[31:16], lo[31:16], hi[15:0], lo[15:0]};
  endfunction

  // Transmit-side model of what the receiver must reassemble
  task automatic sb_word(input logic [31:0] w);
    if (!have_lo) begin
      lo_hold = w;
      have_lo = 1'b1;
    end else begin
      exp_q.push_back(pack(lo_hold, w));
      have_lo = 1'b0;
    end
  endtask

  task automatic sb_clear();
    exp_q.delete();
    have_lo = 1'b0;
  endtask

  // Drive one link cycle; kept=0 marks a word the receiver must drop
  task automatic drive(input logic v, input logic [31:0] w, input bit kept);
    @(posedge clk); #1;
    link_valid = v;
    link_data  = w;
    if (v && kept) sb_word(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    link_valid = 1'b0;
    sb_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  // Output monitor: compare accepted payloads and log token pulses
  always @(negedge clk) begin
    if (rst_n && valid_out && ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", 64'(exp_q.size()), 64'd1);
      else check("payload", data_out, exp_q.pop_front());
      n_payloads++;
    end
    if (rst_n && token_out) tok_cyc.push_back(cyc);
  end

  initial begin
    rst_n = 1'b0;
    link_valid = 1'b0;
    link_data = '0;
    ready = 1'b1;
    have_lo = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_data", data_out, 64'd0);
    check("rst_token", 64'(token_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    check("rst_count", 64'(dbg_count), 64'd0);
    rst_n = 1'b1;

    // Single frame, ready=1: valid only in cycle 3
    tok_cyc.delete();
    n_payloads = 0;
    drive(1'b1, 32'h66552211, 1'b1);
    @(negedge clk); check("sf_valid_c0", 64'(valid_out), 64'd0);
    drive(1'b1, 32'h88774433, 1'b1);
    @(negedge clk); check("sf_valid_c1", 64'(valid_out), 64'd0);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk); check("sf_valid_c2", 64'(valid_out), 64'd0);
    @(negedge clk); check("sf_valid_c3", 64'(valid_out), 64'd1);
    check("sf_data", data_out, 64'h8877665544332211);
    @(negedge clk); check("sf_valid_c4", 64'(valid_out), 64'd0);
    repeat (4) @(negedge clk);
    check("sf_no_token", 64'(tok_cyc.size()), 64'd0);
    check("sf_payloads", 64'(n_payloads), 64'd1);

    // Token cadence: 8 back-to-back words, pops in cycles 1..8
    do_reset();
    tok_cyc.delete();
    n_payloads = 0;
    drive(1'b1, 32'hA0A1A2A3, 1'b1);
    c0 = cyc;
    for (int i = 1; i < 8; i++) drive(1'b1, 32'hA0A1A2A3 + 32'(i * 32'h01010101), 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    wait_drain("tc_drain", 40);
    check("tc_tokens", 64'(tok_cyc.size()), 64'd2);
    check("tc_tok0_cycle", 64'(tok_cyc[0] - c0), 64'd5);
    check("tc_tok1_cycle", 64'(tok_cyc[1] - c0), 64'd9);
    check("tc_payloads", 64'(n_payloads), 64'd4);

    // Wrap-around: 40 words, credit-honouring transmitter, random ready
    do_reset();
    tok_cyc.delete();
    n_payloads = 0;
    credits = DEPTH;
    begin
      int sent = 0;
      for (int t = 0; t < 3000 && (sent < 40 || exp_q.size() != 0); t++) begin
        @(posedge clk); #1;
        if (token_out) credits += TOKEN_WORDS;
        ready = 1'($urandom_range(0, 1));
        if (sent < 40 && credits > 0 && $urandom_range(0, 3) != 0) begin
          link_valid = 1'b1;
          link_data  = $urandom();
          sb_word(link_data);
          credits--;
          sent++;
        end else begin
          link_valid = 1'b0;
        end
      end
      check("wr_sent", 64'(sent), 64'd40);
    end
    @(posedge clk); #1;
    link_valid = 1'b0;
    ready = 1'b1;
    wait_drain("wr_drain", 40);
    check("wr_payloads", 64'(n_payloads), 64'd20);
    check("wr_tokens", 64'(tok_cyc.size()), 64'd10);
    check("wr_overflow", 64'(overflow), 64'd0);

    // Backpressure and overflow, ready=0
    do_reset();
    n_payloads = 0;
    ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h10000000 + 32'(i * 32'h00110011), 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("bp_valid", 64'(valid_out), 64'd1);
    check("bp_count6", 64'(dbg_count), 64'd6);
    check("bp_hold", data_out, pack(32'h10000000, 32'h10110011));
    check("bp_no_ovf", 64'(overflow), 64'd0);
    drive(1'b1, 32'h12345678, 1'b1);
    drive(1'b1, 32'h9ABCDEF0, 1'b1);
    drive(1'b1, 32'hDEADBEEF, 1'b0);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_count8", 64'(dbg_count), 64'd8);
    check("bp_hold2", data_out, pack(32'h10000000, 32'h10110011));
    @(posedge clk); #1;
    ready = 1'b1;
    wait_drain("bp_drain", 40);
    check("bp_payloads", 64'(n_payloads), 64'd5);
    check("bp_idle", 64'(valid_out), 64'd0);

    // Simultaneous push and pop at full
    do_reset();
    n_payloads = 0;
    ready = 1'b0;
    for (int i = 0; i < 10; i++) drive(1'b1, 32'h20202020 ^ 32'(i * 32'h01020304), 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("sp_full", 64'(dbg_count), 64'd8);
    check("sp_state_out", 64'(dbg_state), 64'd2);
    @(posedge clk); #1;
    link_valid = 1'b1;
    link_data = 32'hBADBAD00;
    ready = 1'b1;
    @(posedge clk); #1;
    link_valid = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    check("sp_count7", 64'(dbg_count), 64'd7);
    check("sp_overflow", 64'(overflow), 64'd1);
    @(posedge clk); #1;
    ready = 1'b1;
    wait_drain("sp_drain", 40);
    check("sp_payloads", 64'(n_payloads), 64'd5);

    // Reset mid-frame (overflow is still set from the case above)
    n_payloads = 0;
    drive(1'b1, 32'h66552211, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    begin
      int w = 0;
      while (w < 20 && dbg_state != 2'd1) begin
        @(negedge clk);
        w++;
      end
      check("mr_lo_popped", 64'(dbg_state), 64'd1);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_clear();
    #1;
    check("mr_valid", 64'(valid_out), 64'd0);
    check("mr_token", 64'(token_out), 64'd0);
    check("mr_overflow", 64'(overflow), 64'd0);
    check("mr_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'hDDCCBBAA, 1'b1);
    drive(1'b1, 32'h44332211, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    wait_drain("mr_drain", 20);
    check("mr_data", data_out, 64'h4433DDCC2211BBAA);
    check("mr_payloads", 64'(n_payloads), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
